// File: rtl/chip8_mem_arbiter.sv
// CPU/video arbiter for the 4096x8 CHIP-8 memory: fixed CPU priority with a video anti-starvation
// burst limit, registered memory command, and a two-stage read-return tag pipeline. Option: CHIP8_FONT_PROTECT_EN.
module chip8_mem_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [11:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [7:0]  cpu_rdata,
  input  logic        vid_req,
  input  logic        vid_we,
  input  logic [11:0] vid_addr,
  input  logic [7:0]  vid_wdata,
  output logic        vid_gnt,
  output logic        vid_rvalid,
  output logic [7:0]  vid_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [11:0] mem_address,
  output logic [7:0]  mem_data_in,
  input  logic [7:0]  mem_data_out,
  output logic        prot_err
);

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VID  = 2'd2
  } owner_t;

  owner_t      tag_s1, tag_s2, tag_s1_next;
  logic [3:0]  burst_cnt, burst_next;
  logic        burst_full;
  logic        cpu_take, vid_take, any_take;
  logic        sel_we, sel_blocked;
  logic [11:0] sel_addr;
  logic [7:0]  sel_wdata;
  logic [7:0]  cpu_rdata_q, vid_rdata_q;

  // Grants are gated by rst_n so they drop combinationally while reset is held.
  always_comb begin
    burst_full = (burst_cnt == BURST_LIMIT);
    cpu_take   = rst_n && cpu_req && !(vid_req && burst_full);
    vid_take   = rst_n && vid_req && !cpu_take;
    any_take   = cpu_take || vid_take;
  end

  assign cpu_gnt = cpu_take;
  assign vid_gnt = vid_take;

  always_comb begin
    sel_we    = cpu_we;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    if (vid_take) begin
      sel_we    = vid_we;
      sel_addr  = vid_addr;
      sel_wdata = vid_wdata;
    end
  end

`ifdef CHIP8_FONT_PROTECT_EN
  assign sel_blocked = sel_we && (sel_addr[11:9] == 3'b000);
`else
  assign sel_blocked = 1'b0;
`endif

  always_comb begin
    burst_next = burst_cnt;
    if (!vid_req || vid_take) begin
      burst_next = '0;
    end else if (cpu_take && !burst_full) begin
      burst_next = burst_cnt + 4'd1;
    end
  end

  always_comb begin
    tag_s1_next = OWN_NONE;
    if (cpu_take && !cpu_we) begin
      tag_s1_next = OWN_CPU;
    end else if (vid_take && !vid_we) begin
      tag_s1_next = OWN_VID;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt   <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      tag_s1      <= OWN_NONE;
      tag_s2      <= OWN_NONE;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
    end else begin
      burst_cnt <= burst_next;
      mem_read  <= any_take && !sel_we;
      mem_write <= any_take && sel_we && !sel_blocked;
      if (any_take) begin
        mem_address <= sel_addr;
        mem_data_in <= sel_wdata;
      end
      tag_s1 <= tag_s1_next;
      tag_s2 <= tag_s1;
      if (tag_s2 == OWN_CPU) cpu_rdata_q <= mem_data_out;
      if (tag_s2 == OWN_VID) vid_rdata_q <= mem_data_out;
    end
  end

  // Return data comes straight from memory in the valid cycle, then is held from the capture register.
  assign cpu_rvalid = (tag_s2 == OWN_CPU);
  assign vid_rvalid = (tag_s2 == OWN_VID);
  assign cpu_rdata  = cpu_rvalid ? mem_data_out : cpu_rdata_q;
  assign vid_rdata  = vid_rvalid ? mem_data_out : vid_rdata_q;

`ifdef CHIP8_FONT_PROTECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prot_err <= 1'b0;
    end else begin
      prot_err <= any_take && sel_blocked;
    end
  end
`else
  assign prot_err = 1'b0;
`endif

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Directed self-checking bench for chip8_mem_arbiter with a behavioural 4096x8 synchronous memory.
module tb_chip8_mem_arbiter;

`ifdef CHIP8_FONT_PROTECT_EN
  localparam logic PROT = 1'b1;
`else
  localparam logic PROT = 1'b0;
`endif

  logic        clk, rst_n;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        vid_req, vid_we, vid_gnt, vid_rvalid;
  logic [11:0] vid_addr;
  logic [7:0]  vid_wdata, vid_rdata;
  logic        mem_read, mem_write, prot_err;
  logic [11:0] mem_address;
  logic [7:0]  mem_data_in, mem_data_out;

  logic [7:0]  mem [0:4095];
  int checks = 0;
  int passed = 0;

  chip8_mem_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_we(vid_we), .vid_addr(vid_addr), .vid_wdata(vid_wdata),
    .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .prot_err(prot_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write) mem[mem_address] <= mem_data_in;
    if (mem_read) mem_data_out <= mem[mem_address];
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vid_req = 1'b0; vid_we = 1'b0; vid_addr = '0; vid_wdata = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cpu_req = 1'b1;
    vid_req = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++; if (cpu_gnt !== 1'b0) $display("FAIL reset_cpu_gnt: got %b expected 0", cpu_gnt); else passed++;
    checks++; if (vid_gnt !== 1'b0) $display("FAIL reset_vid_gnt: got %b expected 0", vid_gnt); else passed++;
    checks++; if ({mem_read, mem_write, prot_err, cpu_rvalid, vid_rvalid} !== 5'b0)
      $display("FAIL reset_flags: got %b expected 00000", {mem_read, mem_write, prot_err, cpu_rvalid, vid_rvalid}); else passed++;
    checks++; if ({mem_address, mem_data_in} !== 20'h0)
      $display("FAIL reset_mem_bus: got %h expected 00000", {mem_address, mem_data_in}); else passed++;
    checks++; if ({cpu_rdata, vid_rdata} !== 16'h0)
      $display("FAIL reset_rdata: got %h expected 0000", {cpu_rdata, vid_rdata}); else passed++;
    next_cycle();
    idle();
    rst_n = 1'b1;
  endtask

  task automatic test_cpu_read;
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h200;
    @(negedge clk);
    checks++; if (cpu_gnt !== 1'b1) $display("FAIL cpu_read_gnt: got %b expected 1", cpu_gnt); else passed++;
    checks++; if (vid_gnt !== 1'b0) $display("FAIL cpu_read_vid_gnt: got %b expected 0", vid_gnt); else passed++;
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if (mem_read !== 1'b1) $display("FAIL cpu_read_mem_read: got %b expected 1", mem_read); else passed++;
    checks++; if (mem_address !== 12'h200) $display("FAIL cpu_read_addr: got %h expected 200", mem_address); else passed++;
    checks++; if (cpu_rvalid !== 1'b0) $display("FAIL cpu_read_early_rvalid: got %b expected 0", cpu_rvalid); else passed++;
    next_cycle();
    @(negedge clk);
    checks++; if (cpu_rvalid !== 1'b1) $display("FAIL cpu_read_rvalid: got %b expected 1", cpu_rvalid); else passed++;
    checks++; if (cpu_rdata !== 8'hA2) $display("FAIL cpu_read_rdata: got %h expected a2", cpu_rdata); else passed++;
    checks++; if (vid_rvalid !== 1'b0) $display("FAIL cpu_read_vid_rvalid: got %b expected 0", vid_rvalid); else passed++;
    next_cycle();
    @(negedge clk);
    checks++; if (cpu_rvalid !== 1'b0) $display("FAIL cpu_read_rvalid_pulse: got %b expected 0", cpu_rvalid); else passed++;
    checks++; if (cpu_rdata !== 8'hA2) $display("FAIL cpu_read_rdata_hold: got %h expected a2", cpu_rdata); else passed++;
    checks++; if (mem_read !== 1'b0) $display("FAIL cpu_read_mem_idle: got %b expected 0", mem_read); else passed++;
  endtask

  task automatic test_burst;
    logic exp_cpu;
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h200;
    vid_req = 1'b1; vid_we = 1'b0; vid_addr = 12'h005;
    for (int i = 0; i < 10; i++) begin
      exp_cpu = ((i % 5) != 4);
      @(negedge clk);
      checks++; if (cpu_gnt !== exp_cpu) $display("FAIL burst_cpu_gnt[%0d]: got %b expected %b", i, cpu_gnt, exp_cpu); else passed++;
      checks++; if (vid_gnt !== !exp_cpu) $display("FAIL burst_vid_gnt[%0d]: got %b expected %b", i, vid_gnt, !exp_cpu); else passed++;
      next_cycle();
    end
    idle();
    repeat (3) next_cycle();
  endtask

  task automatic test_alternate;
    logic exp_cpu;
    next_cycle();
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        cpu_req = (i % 2 == 0); cpu_we = 1'b0; cpu_addr = 12'h000;
        vid_req = (i % 2 == 1); vid_we = 1'b0; vid_addr = 12'h005;
      end else begin
        idle();
      end
      @(negedge clk);
      if (i < 6) begin
        checks++; if (cpu_gnt !== (i % 2 == 0)) $display("FAIL alt_cpu_gnt[%0d]: got %b expected %b", i, cpu_gnt, (i % 2 == 0)); else passed++;
        checks++; if (vid_gnt !== (i % 2 == 1)) $display("FAIL alt_vid_gnt[%0d]: got %b expected %b", i, vid_gnt, (i % 2 == 1)); else passed++;
      end
      if (i >= 2) begin
        exp_cpu = ((i - 2) % 2 == 0);
        checks++; if (cpu_rvalid !== exp_cpu) $display("FAIL alt_cpu_rvalid[%0d]: got %b expected %b", i, cpu_rvalid, exp_cpu); else passed++;
        checks++; if (vid_rvalid !== !exp_cpu) $display("FAIL alt_vid_rvalid[%0d]: got %b expected %b", i, vid_rvalid, !exp_cpu); else passed++;
        if (exp_cpu) begin
          checks++; if (cpu_rdata !== 8'hF0) $display("FAIL alt_cpu_rdata[%0d]: got %h expected f0", i, cpu_rdata); else passed++;
        end else begin
          checks++; if (vid_rdata !== 8'h20) $display("FAIL alt_vid_rdata[%0d]: got %h expected 20", i, vid_rdata); else passed++;
        end
      end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_back_to_back;
    logic [11:0] addrs [3];
    logic [7:0]  datas [3];
    addrs[0] = 12'h200; addrs[1] = 12'h000; addrs[2] = 12'h005;
    datas[0] = 8'hA2;   datas[1] = 8'hF0;   datas[2] = 8'h20;
    next_cycle();
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addrs[i];
      end else begin
        idle();
      end
      @(negedge clk);
      if (i >= 2 && i < 5) begin
        checks++; if (cpu_rvalid !== 1'b1) $display("FAIL b2b_rvalid[%0d]: got %b expected 1", i, cpu_rvalid); else passed++;
        checks++; if (cpu_rdata !== datas[i-2]) $display("FAIL b2b_rdata[%0d]: got %h expected %h", i, cpu_rdata, datas[i-2]); else passed++;
      end else if (i == 5) begin
        checks++; if (cpu_rvalid !== 1'b0) $display("FAIL b2b_rvalid_end: got %b expected 0", cpu_rvalid); else passed++;
        checks++; if (cpu_rdata !== 8'h20) $display("FAIL b2b_rdata_hold: got %h expected 20", cpu_rdata); else passed++;
      end
      next_cycle();
    end
  endtask

  task automatic test_write;
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h050; cpu_wdata = 8'h55;
    @(negedge clk);
    checks++; if (cpu_gnt !== 1'b1) $display("FAIL wr_gnt: got %b expected 1", cpu_gnt); else passed++;
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if (mem_write !== !PROT) $display("FAIL wr_mem_write: got %b expected %b", mem_write, !PROT); else passed++;
    checks++; if (prot_err !== PROT) $display("FAIL wr_prot_err: got %b expected %b", prot_err, PROT); else passed++;
    checks++; if (mem_read !== 1'b0) $display("FAIL wr_mem_read: got %b expected 0", mem_read); else passed++;
    checks++; if (mem_address !== 12'h050) $display("FAIL wr_addr: got %h expected 050", mem_address); else passed++;
    checks++; if (mem_data_in !== 8'h55) $display("FAIL wr_data: got %h expected 55", mem_data_in); else passed++;
    next_cycle();
    @(negedge clk);
    checks++; if (prot_err !== 1'b0) $display("FAIL wr_prot_pulse: got %b expected 0", prot_err); else passed++;
    checks++; if (mem_write !== 1'b0) $display("FAIL wr_mem_write_idle: got %b expected 0", mem_write); else passed++;
    checks++; if (cpu_rvalid !== 1'b0) $display("FAIL wr_no_rvalid: got %b expected 0", cpu_rvalid); else passed++;
    // Boundary of the protected window: 0x1FF is the last protected byte.
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h1FF; cpu_wdata = 8'h11;
    next_cycle();
    cpu_addr = 12'h200; cpu_wdata = 8'h99;
    @(negedge clk);
    checks++; if ({mem_write, prot_err} !== {!PROT, PROT}) $display("FAIL wr_1ff: got %b expected %b", {mem_write, prot_err}, {!PROT, PROT}); else passed++;
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if ({mem_write, prot_err} !== 2'b10) $display("FAIL wr_200: got %b expected 10", {mem_write, prot_err}); else passed++;
    // Read back 0x050: untouched under protection.
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h050;
    next_cycle();
    idle();
    next_cycle();
    @(negedge clk);
    checks++; if (cpu_rdata !== (PROT ? 8'h00 : 8'h55)) $display("FAIL wr_readback: got %h expected %h", cpu_rdata, (PROT ? 8'h00 : 8'h55)); else passed++;
    // Restore 0x200 for later reads.
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h200; cpu_wdata = 8'hA2;
    next_cycle();
    idle();
  endtask

  task automatic test_top_address;
    next_cycle();
    vid_req = 1'b1; vid_we = 1'b1; vid_addr = 12'hFFF; vid_wdata = 8'h3C;
    @(negedge clk);
    checks++; if (vid_gnt !== 1'b1) $display("FAIL top_wr_gnt: got %b expected 1", vid_gnt); else passed++;
    next_cycle();
    vid_we = 1'b0;
    @(negedge clk);
    checks++; if ({mem_write, mem_address} !== {1'b1, 12'hFFF}) $display("FAIL top_wr_bus: got %h expected 1fff", {mem_write, mem_address}); else passed++;
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if ({mem_read, mem_address} !== {1'b1, 12'hFFF}) $display("FAIL top_rd_bus: got %h expected 1fff", {mem_read, mem_address}); else passed++;
    next_cycle();
    @(negedge clk);
    checks++; if ({vid_rvalid, vid_rdata} !== {1'b1, 8'h3C}) $display("FAIL top_rd_data: got %h expected 13c", {vid_rvalid, vid_rdata}); else passed++;
  endtask

  task automatic test_reset_inflight;
    next_cycle();
    vid_req = 1'b1; vid_we = 1'b0; vid_addr = 12'h005;
    @(negedge clk);
    checks++; if (vid_gnt !== 1'b1) $display("FAIL rst_vid_gnt: got %b expected 1", vid_gnt); else passed++;
    next_cycle();
    idle();
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_addr = 12'h200;
    @(negedge clk);
    checks++; if ({cpu_gnt, vid_gnt} !== 2'b00) $display("FAIL rst_gnts: got %b expected 00", {cpu_gnt, vid_gnt}); else passed++;
    checks++; if ({mem_read, mem_write, prot_err, cpu_rvalid, vid_rvalid} !== 5'b0)
      $display("FAIL rst_flags: got %b expected 00000", {mem_read, mem_write, prot_err, cpu_rvalid, vid_rvalid}); else passed++;
    checks++; if ({mem_address, mem_data_in, cpu_rdata, vid_rdata} !== 36'h0)
      $display("FAIL rst_buses: got %h expected 0", {mem_address, mem_data_in, cpu_rdata, vid_rdata}); else passed++;
    next_cycle();
    @(negedge clk);
    checks++; if (vid_rvalid !== 1'b0) $display("FAIL rst_vid_rvalid: got %b expected 0", vid_rvalid); else passed++;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (cpu_gnt !== 1'b1) $display("FAIL rst_resume_gnt: got %b expected 1", cpu_gnt); else passed++;
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if ({mem_read, mem_address, vid_rvalid} !== {1'b1, 12'h200, 1'b0})
      $display("FAIL rst_resume_cmd: got %h expected 2400", {mem_read, mem_address, vid_rvalid}); else passed++;
    next_cycle();
    @(negedge clk);
    checks++; if ({cpu_rvalid, cpu_rdata, vid_rvalid} !== {1'b1, 8'hA2, 1'b0})
      $display("FAIL rst_resume_ret: got %h expected 344", {cpu_rvalid, cpu_rdata, vid_rvalid}); else passed++;
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
    mem[12'h000] = 8'hF0; mem[12'h001] = 8'h90; mem[12'h002] = 8'h90; mem[12'h003] = 8'h90; mem[12'h004] = 8'hF0;
    mem[12'h005] = 8'h20; mem[12'h006] = 8'h60; mem[12'h007] = 8'h20; mem[12'h008] = 8'h20; mem[12'h009] = 8'h70;
    mem[12'h200] = 8'hA2;
    mem_data_out = 8'h00;
    idle();
    test_reset();
    test_cpu_read();
    test_burst();
    test_alternate();
    test_back_to_back();
    test_write();
    test_top_address();
    test_reset_inflight();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/chip8_mem_arbiter.md
CHIP8_MEM_ARBITER -- requirements
Module: chip8_mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, max consecutive CPU grants while video waits (range 1-15).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port cpu_req  input  1  CPU access request, held until granted.
REQ-005 SHALL have port cpu_we  input  1  CPU write (1) / read (0).
REQ-006 SHALL have ports cpu_addr  input  12  and  cpu_wdata  input  8  CPU address and write data.
REQ-007 SHALL have ports cpu_gnt  output  1  (accept this cycle), cpu_rvalid  output  1  and  cpu_rdata  output  8  (read return).
REQ-008 SHALL have ports vid_req, vid_we, vid_addr[11:0], vid_wdata[7:0] (inputs) and vid_gnt, vid_rvalid, vid_rdata[7:0] (outputs), same meaning for the video/sprite requester.
REQ-009 SHALL have ports mem_read  output  1,  mem_write  output  1,  mem_address  output  12,  mem_data_in  output  8  driving the 4096x8 memory.
REQ-010 SHALL have port mem_data_out  input  8  memory read data, valid one cycle after the memory samples a read.
REQ-011 SHALL have port prot_err  output  1  one-cycle pulse on a blocked write.

Function
REQ-012 SHALL grant at most one requester per cycle; x_gnt combinational from x_req and arbiter state; transfer occurs when x_req and x_gnt are both high.
REQ-013 SHALL give CPU fixed priority, except vid wins when the burst counter equals MAX_BURST.
REQ-014 SHALL increment the 4-bit burst counter on each CPU grant while vid_req is high; clear it on any vid grant or any cycle with vid_req low; never exceed MAX_BURST.
REQ-015 SHALL register the granted command onto mem_* at the grant edge (cycle N+1 drive); mem_read/mem_write low in cycles with no grant.
REQ-016 SHALL track read ownership in a 2-stage tag pipeline; read granted in cycle N returns x_rvalid=1 with x_rdata=mem_data_out in cycle N+2, for exactly one cycle.
REQ-017 SHALL sustain one access per cycle; back-to-back reads from either or alternating requesters each return in order at N+2.
REQ-018 SHALL never assert rvalid for a write; x_rdata holds last returned value when rvalid low.
REQ-019 SHALL pass addresses unmodified (12-bit, no wrap logic; 0xFFF is valid).
REQ-020 SHALL hold vid_gnt low while cpu_req high unless REQ-013 exception applies; simultaneous requests with counter < MAX_BURST grant CPU.

Reset
REQ-021 SHALL, while rst_n low, force gnts (combinationally), rvalids, mem_read, mem_write, prot_err to 0; mem_address, mem_data_in, rdata, burst counter to 0.
REQ-022 SHALL discard in-flight reads on reset; no rvalid for requests granted before reset.
REQ-023 SHALL resume arbitration on the first rising edge after rst_n deasserts.

Configuration
REQ-024 SHALL, with CHIP8_FONT_PROTECT_EN defined, grant writes to addresses 0x000-0x1FF but keep mem_write low for them and pulse prot_err in cycle N+1.
REQ-025 SHALL, without CHIP8_FONT_PROTECT_EN, pass all writes and tie prot_err to 0.

Verification
REQ-026 CPU read 0x200 (memory holds 0xA2), vid idle -> cpu_gnt same cycle, mem_read/mem_address=0x200 next cycle, cpu_rvalid=1 cpu_rdata=0xA2 two cycles after grant.
REQ-027 cpu_req and vid_req held high 10 cycles, MAX_BURST=4 -> grant pattern C,C,C,C,V,C,C,C,C,V.
REQ-028 Alternating CPU read 0x000 / vid read 0x005 every cycle -> rvalid alternates, rdata 0xF0 and 0x20 in order, one per cycle.
REQ-029 CPU write 0x050 data 0x55 with macro defined -> cpu_gnt=1, mem_write stays 0, prot_err=1 one cycle; without macro -> mem_write=1, data 0x55, prot_err=0.
REQ-030 Vid read granted, rst_n pulled low next cycle -> vid_rvalid never asserts, all outputs 0 during reset, first grant after release behaves per REQ-026.
